// File: rtl/sim_host_port.sv
// sim_host_port: collects characters from several simulation channels into
// per-channel FIFOs, merges them round-robin onto one ready/valid stream, and
// ends the run on an exit request (after draining) or on a watchdog timeout.
module sim_host_port #(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT_W  = 32
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [CHANNELS-1:0]                              wr_en,
    input  logic [CHANNELS*DATA_W-1:0]                       wr_data,
    output logic [CHANNELS-1:0]                              wr_full,
    output logic [CHANNELS-1:0]                              overflow,
    input  logic                                             exit_en,
    input  logic [DATA_W-1:0]                                exit_code,
    input  logic [TIMEOUT_W-1:0]                             timeout_limit,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [DATA_W-1:0]                                out_data,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_chan,
    output logic                                             terminate,
    output logic [DATA_W-1:0]                                term_code,
    output logic                                             term_cause
);

    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0]    mem [CHANNELS][FIFO_DEPTH];
    logic [PW-1:0]        wp [CHANNELS];
    logic [PW-1:0]        rp [CHANNELS];
    logic [CHANNELS-1:0]  empty, full, push, pop, drop;
    logic [CW-1:0]        rr_q;
    logic                 gnt_found;
    logic [CW-1:0]        gnt_idx;
    logic [DATA_W-1:0]    gnt_data;
    logic                 load;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic                 timeout_hit;
    logic                 drained;
    logic                 enter_done;
    logic                 cause_d;
    logic [DATA_W-1:0]    code_d;

    assign wr_full     = full;
    assign timeout_hit = (timeout_limit != '0) && (cnt_q == timeout_limit - TIMEOUT_W'(1));
    assign drained     = (&empty) && !out_valid;

    // Per-channel FIFO occupancy flags.
    always_comb begin
        empty = '0;
        full  = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            empty[c] = (wp[c] == rp[c]);
            full[c]  = ((wp[c] - rp[c]) == PW'(FIFO_DEPTH));
        end
    end

    // Round-robin search for the first non-empty channel starting at rr_q.
    always_comb begin
        int unsigned idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_data  = '0;
        idx       = 0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!gnt_found && !empty[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = CW'(idx);
                gnt_data  = mem[idx][rp[idx][AW-1:0]];
            end
        end
    end

    // Next state and termination result.
    always_comb begin
        state_d    = state_q;
        enter_done = 1'b0;
        cause_d    = term_cause;
        code_d     = term_code;
        case (state_q)
            ST_RUN: begin
                if (exit_en) begin
                    state_d = ST_DRAIN;
                    code_d  = exit_code;
                end else if (timeout_hit) begin
                    state_d    = ST_DONE;
                    enter_done = 1'b1;
                    cause_d    = 1'b1;
                    code_d     = '1;
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    state_d    = ST_DONE;
                    enter_done = 1'b1;
                    cause_d    = 1'b0;
                end else if (timeout_hit) begin
                    state_d    = ST_DONE;
                    enter_done = 1'b1;
                    cause_d    = 1'b1;
                    code_d     = '1;
                end
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
    end

    // FIFO push/pop/drop decisions; a pop frees room for a push at the same edge.
    always_comb begin
        load = (state_q != ST_DONE) && (state_d != ST_DONE) && (!out_valid || out_ready);
        push = '0;
        pop  = '0;
        drop = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            pop[c]  = load && gnt_found && (gnt_idx == CW'(c));
            push[c] = (state_q == ST_RUN) && wr_en[c] && (!full[c] || pop[c]);
            drop[c] = (state_q == ST_RUN) && wr_en[c] && full[c] && !pop[c];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (push[c]) begin
                mem[c][wp[c][AW-1:0]] <= wr_data[c*DATA_W +: DATA_W];
            end
        end
    end

    // Pointers, overflow flags, watchdog, output register and termination.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                wp[c] <= '0;
                rp[c] <= '0;
            end
            overflow   <= '0;
            cnt_q      <= '0;
            rr_q       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            terminate  <= 1'b0;
            term_code  <= '0;
            term_cause <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (push[c]) begin
                    wp[c] <= wp[c] + PW'(1);
                end
                if (pop[c]) begin
                    rp[c] <= rp[c] + PW'(1);
                end
                if (drop[c]) begin
                    overflow[c] <= 1'b1;
                end
            end
            if ((state_q != ST_DONE) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + TIMEOUT_W'(1);
            end
            if (state_d == ST_DONE) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid <= gnt_found;
                if (gnt_found) begin
                    out_data <= gnt_data;
                    out_chan <= gnt_idx;
                    rr_q     <= (gnt_idx == CW'(CHANNELS - 1)) ? '0 : gnt_idx + CW'(1);
                end
            end
            term_code  <= code_d;
            term_cause <= cause_d;
            if (enter_done) begin
                terminate <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sim_host_port.sv
// Self-checking bench for sim_host_port with default parameters.
module tb_sim_host_port;

    localparam int CH = 2;
    localparam int DW = 8;
    localparam int FD = 4;
    localparam int TW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   wr_en;
    logic [CH*DW-1:0] wr_data;
    logic [CH-1:0]   wr_full;
    logic [CH-1:0]   overflow;
    logic            exit_en;
    logic [DW-1:0]   exit_code;
    logic [TW-1:0]   timeout_limit;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [0:0]      out_chan;
    logic            terminate;
    logic [DW-1:0]   term_code;
    logic            term_cause;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] got[$];
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];

    sim_host_port #(
        .CHANNELS(CH), .DATA_W(DW), .FIFO_DEPTH(FD), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
        .overflow(overflow), .exit_en(exit_en), .exit_code(exit_code),
        .timeout_limit(timeout_limit), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_chan(out_chan), .terminate(terminate),
        .term_code(term_code), .term_cause(term_cause)
    );

    always #5 clk = ~clk;

    // One clock; records the handshake that completes at this edge.
    task automatic tick();
        if (out_valid && out_ready) got.push_back({out_chan, out_data});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = '0; wr_data = '0; exit_en = 1'b0; exit_code = '0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
        got.delete();
    endtask

    task automatic test_reset();
        timeout_limit = '0;
        do_reset();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        vectors++; if (terminate !== 1'b0) begin miscompares++; $display("FAIL reset_terminate got %0b want 0", terminate); end
        vectors++; if (wr_full !== 2'b00) begin miscompares++; $display("FAIL reset_wr_full got %b want 00", wr_full); end
        vectors++; if (overflow !== 2'b00) begin miscompares++; $display("FAIL reset_overflow got %b want 00", overflow); end
        vectors++; if ({term_cause, term_code} !== 9'h000) begin miscompares++; $display("FAIL reset_term got %h want 000", {term_cause, term_code}); end
    endtask

    task automatic test_single_char();
        do_reset();
        out_ready = 1'b1;
        repeat (4) tick();
        wr_en = 2'b01; wr_data = 16'h0041;
        tick();
        wr_en = '0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_early got valid=%0b want 0", out_valid); end
        tick();
        vectors++; if ({out_valid, out_chan, out_data} !== {1'b1, 1'b0, 8'h41}) begin
            miscompares++; $display("FAIL single_char got v=%0b ch=%0d d=%h want v=1 ch=0 d=41", out_valid, out_chan, out_data); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_after got valid=%0b want 0", out_valid); end
    endtask

    task automatic test_round_robin();
        logic [8:0] want[4];
        want[0] = {1'b0, 8'h10}; want[1] = {1'b1, 8'h20}; want[2] = {1'b0, 8'h11}; want[3] = {1'b1, 8'h21};
        do_reset();
        out_ready = 1'b1;
        wr_en = 2'b11; wr_data = 16'h2010; tick();
        wr_data = 16'h2111; tick();
        wr_en = '0;
        repeat (4) tick();
        vectors++; if (got.size() != 4) begin miscompares++; $display("FAIL rr_throughput got %0d chars want 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= got.size()) begin miscompares++; $display("FAIL rr_order[%0d] got none want %h", i, want[i]); end
            else if (got[i] !== want[i]) begin miscompares++; $display("FAIL rr_order[%0d] got %h want %h", i, got[i], want[i]); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 2'b01; wr_data = {8'h00, 8'(8'h30 + i)};
            tick();
            vectors++; if (overflow[0] !== 1'b0) begin miscompares++; $display("FAIL ovf_early[%0d] got %0b want 0", i, overflow[0]); end
        end
        vectors++; if (wr_full[0] !== 1'b1) begin miscompares++; $display("FAIL ovf_full got %0b want 1", wr_full[0]); end
        vectors++; if ({out_valid, out_data} !== {1'b1, 8'h30}) begin miscompares++; $display("FAIL ovf_hold got v=%0b d=%h want v=1 d=30", out_valid, out_data); end
        wr_data = 16'h0035; tick();
        wr_en = '0;
        vectors++; if (overflow[0] !== 1'b1) begin miscompares++; $display("FAIL ovf_set got %0b want 1", overflow[0]); end
        out_ready = 1'b1;
        repeat (10) tick();
        vectors++; if (got.size() != 5) begin miscompares++; $display("FAIL ovf_count got %0d want 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            vectors++; if (got[i] !== {1'b0, 8'(8'h30 + i)}) begin miscompares++; $display("FAIL ovf_data[%0d] got %h want %h", i, got[i], {1'b0, 8'(8'h30 + i)}); end
        end
        vectors++; if (overflow[0] !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %0b want 1", overflow[0]); end
    endtask

    task automatic test_exit_drain();
        int n;
        timeout_limit = '0;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 2'b10; wr_data = {8'(8'h51 + i), 8'h00}; tick();
        end
        wr_en = '0;
        exit_en = 1'b1; exit_code = 8'h07; tick();
        exit_en = 1'b0;
        wr_en = 2'b01; wr_data = 16'h0099; tick();
        wr_en = '0;
        vectors++; if (terminate !== 1'b0) begin miscompares++; $display("FAIL drain_early_term got %0b want 0", terminate); end
        out_ready = 1'b1;
        n = 0;
        while (!terminate && n < 60) begin tick(); n++; end
        vectors++; if (terminate !== 1'b1) begin miscompares++; $display("FAIL drain_timeout got terminate=%0b want 1", terminate); end
        vectors++; if (got.size() != 3) begin miscompares++; $display("FAIL drain_count got %0d want 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            vectors++; if (got[i] !== {1'b1, 8'(8'h51 + i)}) begin miscompares++; $display("FAIL drain_data[%0d] got %h want %h", i, got[i], {1'b1, 8'(8'h51 + i)}); end
        end
        vectors++; if ({term_cause, term_code} !== {1'b0, 8'h07}) begin miscompares++; $display("FAIL drain_term got %h want 007", {term_cause, term_code}); end
        vectors++; if ({overflow, out_valid} !== 3'b000) begin miscompares++; $display("FAIL drain_flags got ovf=%b v=%0b want 00/0", overflow, out_valid); end
    endtask

    task automatic test_timeout();
        timeout_limit = 32'd100;
        do_reset();
        repeat (99) tick();
        vectors++; if (terminate !== 1'b0) begin miscompares++; $display("FAIL tmo_early got %0b want 0", terminate); end
        tick();
        vectors++; if ({terminate, term_cause, term_code} !== {1'b1, 1'b1, 8'hFF}) begin
            miscompares++; $display("FAIL tmo_fire got t=%0b c=%0b code=%h want 1 1 ff", terminate, term_cause, term_code); end
        exit_en = 1'b1; exit_code = 8'h12; wr_en = 2'b11; out_ready = 1'b1;
        repeat (5) tick();
        exit_en = 1'b0; wr_en = '0;
        vectors++; if ({terminate, term_cause, term_code, out_valid, overflow} !== {1'b1, 1'b1, 8'hFF, 1'b0, 2'b00}) begin
            miscompares++; $display("FAIL tmo_done_frozen got t=%0b c=%0b code=%h v=%0b ovf=%b", terminate, term_cause, term_code, out_valid, overflow); end
    endtask

    task automatic test_timeout_disabled();
        int fired;
        timeout_limit = '0;
        do_reset();
        fired = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (terminate) fired = 1;
        end
        vectors++; if (fired != 0) begin miscompares++; $display("FAIL tmo_disabled got terminate seen want none"); end
    endtask

    task automatic test_exit_vs_timeout();
        timeout_limit = 32'd10;
        do_reset();
        repeat (9) tick();
        exit_en = 1'b1; exit_code = 8'h5A; tick();
        exit_en = 1'b0;
        vectors++; if (terminate !== 1'b0) begin miscompares++; $display("FAIL prio_drain got terminate=%0b want 0", terminate); end
        tick();
        vectors++; if ({terminate, term_cause, term_code} !== {1'b1, 1'b0, 8'h5A}) begin
            miscompares++; $display("FAIL prio_exit got t=%0b c=%0b code=%h want 1 0 5a", terminate, term_cause, term_code); end
    endtask

    task automatic test_timeout_in_drain();
        int n;
        timeout_limit = 32'd30;
        do_reset();
        out_ready = 1'b0;
        wr_en = 2'b01; wr_data = 16'h0001; tick();
        wr_data = 16'h0002; tick();
        wr_en = '0;
        exit_en = 1'b1; exit_code = 8'h33; tick();
        exit_en = 1'b0;
        n = 0;
        while (!terminate && n < 60) begin tick(); n++; end
        vectors++; if ({terminate, term_cause, term_code, out_valid} !== {1'b1, 1'b1, 8'hFF, 1'b0}) begin
            miscompares++; $display("FAIL drain_tmo got t=%0b c=%0b code=%h v=%0b want 1 1 ff 0", terminate, term_cause, term_code, out_valid); end
    endtask

    task automatic test_reset_in_drain();
        timeout_limit = '0;
        do_reset();
        out_ready = 1'b0;
        wr_en = 2'b01; wr_data = 16'h0061; tick();
        wr_data = 16'h0062; tick();
        wr_en = '0;
        exit_en = 1'b1; exit_code = 8'h44; tick();
        exit_en = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        vectors++; if ({out_valid, terminate, wr_full, overflow, term_code} !== 14'h0) begin
            miscompares++; $display("FAIL rst_drain got v=%0b t=%0b full=%b ovf=%b code=%h want all 0", out_valid, terminate, wr_full, overflow, term_code); end
        out_ready = 1'b1;
        wr_en = 2'b10; wr_data = 16'h7700; tick();
        wr_en = '0; tick();
        vectors++; if ({out_valid, out_chan, out_data} !== {1'b1, 1'b1, 8'h77}) begin
            miscompares++; $display("FAIL rst_run got v=%0b ch=%0d d=%h want 1 1 77", out_valid, out_chan, out_data); end
        got.delete();
    endtask

    // Random traffic; per-channel order must be preserved with nothing lost.
    task automatic test_random();
        logic [8:0] e;
        logic [7:0] b;
        timeout_limit = '0;
        do_reset();
        exp0.delete(); exp1.delete();
        for (int cyc = 0; cyc < 340; cyc++) begin
            wr_en = '0;
            out_ready = (cyc >= 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (cyc < 300) begin
                if ($urandom_range(0, 1) == 1 && exp0.size() < FD) begin
                    b = 8'($urandom); wr_en[0] = 1'b1; wr_data[7:0] = b; exp0.push_back(b);
                end
                if ($urandom_range(0, 1) == 1 && exp1.size() < FD) begin
                    b = 8'($urandom); wr_en[1] = 1'b1; wr_data[15:8] = b; exp1.push_back(b);
                end
            end
            tick();
            while (got.size() > 0) begin
                e = got.pop_front();
                vectors++;
                if (e[8] == 1'b0) begin
                    if (exp0.size() == 0) begin miscompares++; $display("FAIL rand_ch0 got %h want none", e[7:0]); end
                    else begin b = exp0.pop_front(); if (e[7:0] !== b) begin miscompares++; $display("FAIL rand_ch0 got %h want %h", e[7:0], b); end end
                end else begin
                    if (exp1.size() == 0) begin miscompares++; $display("FAIL rand_ch1 got %h want none", e[7:0]); end
                    else begin b = exp1.pop_front(); if (e[7:0] !== b) begin miscompares++; $display("FAIL rand_ch1 got %h want %h", e[7:0], b); end end
                end
            end
        end
        vectors++; if (exp0.size() + exp1.size() != 0) begin miscompares++; $display("FAIL rand_leftover got %0d undelivered want 0", exp0.size() + exp1.size()); end
        vectors++; if (overflow !== 2'b00) begin miscompares++; $display("FAIL rand_overflow got %b want 00", overflow); end
    endtask

    initial begin
        rst = 1'b1; wr_en = '0; wr_data = '0; exit_en = 1'b0; exit_code = '0;
        timeout_limit = '0; out_ready = 1'b0;
        test_reset();
        test_single_char();
        test_round_robin();
        test_overflow();
        test_exit_drain();
        test_timeout();
        test_timeout_disabled();
        test_exit_vs_timeout();
        test_timeout_in_drain();
        test_reset_in_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sim_host_port.md
SIM_HOST_PORT -- requirements
Module: sim_host_port

Interface
REQ-001 SHALL provide parameter CHANNELS, default 2: number of character channels, 1..8.
REQ-002 SHALL provide parameter DATA_W, default 8: character and exit-code width.
REQ-003 SHALL provide parameter FIFO_DEPTH, default 4: per-channel FIFO depth, a power of two, at least 2.
REQ-004 SHALL provide parameter TIMEOUT_W, default 32: watchdog counter width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port wr_en, input, CHANNELS bits: per-channel write strobe, one character per cycle.
REQ-008 SHALL have port wr_data, input, CHANNELS*DATA_W bits: channel c occupies bits [c*DATA_W +: DATA_W].
REQ-009 SHALL have port wr_full, output, CHANNELS bits: channel FIFO full.
REQ-010 SHALL have port overflow, output, CHANNELS bits: sticky flag, set when a write is dropped.
REQ-011 SHALL have port exit_en, input, 1 bit: exit-request strobe.
REQ-012 SHALL have port exit_code, input, DATA_W bits: exit value.
REQ-013 SHALL have port timeout_limit, input, TIMEOUT_W bits: watchdog limit in cycles; 0 disables the watchdog.
REQ-014 SHALL have port out_valid, output, 1 bit: output stream valid.
REQ-015 SHALL have port out_ready, input, 1 bit: output stream ready.
REQ-016 SHALL have port out_data, output, DATA_W bits: character.
REQ-017 SHALL have port out_chan, output, max(1,$clog2(CHANNELS)) bits: source channel of out_data.
REQ-018 SHALL have port terminate, output, 1 bit: run finished; held high until reset.
REQ-019 SHALL have port term_code, output, DATA_W bits: captured exit value.
REQ-020 SHALL have port term_cause, output, 1 bit: 0 = exit request, 1 = watchdog timeout.

Function
REQ-021 SHALL implement the state machine RUN -> DRAIN -> DONE; reset enters RUN.
REQ-022 SHALL, in RUN, push wr_data[c] into FIFO c at each edge where wr_en[c]=1 and wr_full[c]=0.
REQ-023 SHALL drop a write to a full FIFO and set overflow[c]; overflow is cleared only by rst.
REQ-024 SHALL assert wr_full[c] combinationally from FIFO occupancy == FIFO_DEPTH.
REQ-025 SHALL hold out_data, out_chan and out_valid in an output register; when out_valid=1 and out_ready=0, all three are held stable.
REQ-026 SHALL load the output register at an edge where out_valid=0, or where out_valid=1 and out_ready=1, from the first non-empty channel after the last-granted channel (round-robin).
REQ-027 SHALL start the round-robin search at channel 0 after reset.
REQ-028 SHALL, when a character is written at edge k into an empty FIFO with the output register free, present it with out_valid=1 after edge k+1.
REQ-029 SHALL sustain one character per cycle when out_ready is held high.
REQ-030 SHALL allow a push and a pop on the same FIFO at the same edge while full; the push is accepted.
REQ-031 SHALL, on exit_en=1 in RUN, capture exit_code into term_code and go to DRAIN.
REQ-032 SHALL, in DRAIN, ignore wr_en without setting overflow, and continue the output stream.
REQ-033 SHALL leave DRAIN for DONE at the first edge where all FIFOs are empty and out_valid=0.
REQ-034 SHALL, with term_cause=0, assert terminate in the cycle after entering DONE via DRAIN.
REQ-035 SHALL increment the watchdog counter every cycle in RUN and DRAIN.
REQ-036 SHALL, when timeout_limit != 0 and the counter equals timeout_limit-1, enter DONE directly with term_cause=1 and term_code all ones.
REQ-037 SHALL give exit_en priority over a timeout occurring in the same cycle.
REQ-038 SHALL allow the watchdog to fire during DRAIN: term_cause=1 and term_code is overwritten with all ones.
REQ-039 SHALL, in DONE, force out_valid=0, freeze the FIFOs, ignore wr_en, exit_en and the watchdog, and wrap nothing.
REQ-040 SHALL give the watchdog counter a saturating width of TIMEOUT_W bits; it never wraps.

Reset
REQ-041 SHALL, at an edge with rst=1, clear all FIFOs, overflow, out_valid, out_data, out_chan, term_code, term_cause, terminate, the counter and the round-robin pointer, and enter RUN.
REQ-042 SHALL give rst priority over every other input, including mid-DRAIN and in DONE.
REQ-043 SHALL give wr_full=0 in the cycle after reset.

Verification
REQ-044 SHALL cover a single character: ch0 writes 0x41 at edge 5 with out_ready=1 -> out_valid=1, out_data=0x41, out_chan=0 after edge 6 only.
REQ-045 SHALL cover round-robin: ch0 and ch1 each write 2 bytes simultaneously (0x10, 0x11 / 0x20, 0x21) -> output order is 0x10, 0x20, 0x11, 0x21.
REQ-046 SHALL cover overflow and backpressure: out_ready=0, 5 writes to ch0 with depth 4 -> the output register takes 1 byte, the FIFO fills (wr_full=1), overflow[0] stays 0 until the 6th write; after out_ready=1 all 5 accepted bytes come out in order.
REQ-047 SHALL cover exit with drain: 3 bytes pending, then exit_en with exit_code=0x07 -> all 3 bytes delivered, then terminate=1, term_code=0x07, term_cause=0.
REQ-048 SHALL cover timeout: timeout_limit=100 with no exit -> terminate=1, term_cause=1, term_code=0xFF, entered 100 cycles after reset release; with timeout_limit=0 there is no terminate after 10000 cycles.
REQ-049 SHALL cover reset in DRAIN: rst=1 with 2 bytes queued -> next cycle out_valid=0, terminate=0, wr_full=0, state RUN.
